// File: rtl/agc_gain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : agc_gain_ctrl
//  Description : Gain-control half of the AGC loop. Multiplies the 12-bit I/Q
//                stream by a Q8.8 gain (two pipeline stages, symmetric
//                saturation to +/-2047). The gain is adjusted from the
//                envelope measured downstream on this block's own output.
//                The loop uses a fast attack and a slow decay, a deadband
//                around TARGET, and a lock detector.
//  Ports       : i_clk, i_rst (async, active-low)
//                in_valid/sample_i/sample_q   - input sample stream
//                env_valid/env                - measured output envelope
//                hold                         - freeze the gain loop
//                out_valid/out_i/out_q/out_sat - gained, saturated samples
//                gain                         - current Q8.8 gain
//                locked                       - loop settled indicator
//  Revision    : 1.0 - initial release
// ============================================================================
module agc_gain_ctrl #(
    parameter logic [11:0] TARGET       = 12'd1024,
    parameter logic [11:0] DEADBAND     = 12'd16,
    parameter int          ATTACK_SHIFT = 2,
    parameter int          DECAY_SHIFT  = 6,
    parameter logic [15:0] GAIN_INIT    = 16'h0100,
    parameter logic [15:0] GAIN_MIN     = 16'h0010,
    parameter logic [15:0] GAIN_MAX     = 16'h1000,
    parameter int          LOCK_COUNT   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        in_valid,
    input  logic [11:0] sample_i,
    input  logic [11:0] sample_q,
    input  logic        env_valid,
    input  logic [11:0] env,
    input  logic        hold,
    output logic        out_valid,
    output logic [11:0] out_i,
    output logic [11:0] out_q,
    output logic        out_sat,
    output logic [15:0] gain,
    output logic        locked
);

    localparam int                c_LCW      = $clog2(LOCK_COUNT + 1);
    localparam logic [c_LCW-1:0]  c_LOCK_MAX = c_LCW'(LOCK_COUNT);
    localparam logic [c_LCW-1:0]  c_LOCK_ONE = c_LCW'(1);
    localparam logic signed [20:0] c_SAT_POS = 21'sd2047;
    localparam logic signed [20:0] c_SAT_NEG = -21'sd2047;
    localparam logic [11:0]       c_OUT_POS  = 12'h7FF;
    localparam logic [11:0]       c_OUT_NEG  = 12'h801;
    localparam logic signed [17:0] c_GMIN    = $signed({2'b00, GAIN_MIN});
    localparam logic signed [17:0] c_GMAX    = $signed({2'b00, GAIN_MAX});
    localparam logic signed [12:0] c_DBAND   = $signed({1'b0, DEADBAND});

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [15:0]       gain_q, gain_d;
    logic [c_LCW-1:0]  lock_cnt_q, lock_cnt_d;
    logic              s1_valid_q;
    logic signed [20:0] s1_i_q, s1_q_q;

    // ------------------------------------------------------------------
    // Stage 1: signed sample x unsigned gain, then >>> 8 (floor).
    // Both operands are widened to the full 29-bit product width so the
    // multiply is evaluated signed at full precision. Keeping bits [28:8]
    // of the product is the arithmetic shift by 8.
    // ------------------------------------------------------------------
    logic signed [28:0] w_si_x, w_sq_x, w_g_x;
    logic signed [20:0] w_s1_i, w_s1_q;

    assign w_si_x = 29'($signed(sample_i));
    assign w_sq_x = 29'($signed(sample_q));
    assign w_g_x  = 29'($signed({1'b0, gain_q}));
    assign w_s1_i = 21'((w_si_x * w_g_x) >>> 8);
    assign w_s1_q = 21'((w_sq_x * w_g_x) >>> 8);

    // ------------------------------------------------------------------
    // Stage 2: symmetric saturation to [-2047, +2047].
    // Result is {clipped, value}.
    // ------------------------------------------------------------------
    function automatic logic [12:0] f_sat(input logic signed [20:0] v);
        logic [12:0] r;
        if (v > c_SAT_POS) begin
            r = {1'b1, c_OUT_POS};
        end else if (v < c_SAT_NEG) begin
            r = {1'b1, c_OUT_NEG};
        end else begin
            r = {1'b0, v[11:0]};
        end
        return r;
    endfunction

    logic [12:0] w_sat_i, w_sat_q;
    assign w_sat_i = f_sat(s1_i_q);
    assign w_sat_q = f_sat(s1_q_q);

    // ------------------------------------------------------------------
    // Gain loop
    // ------------------------------------------------------------------
    logic signed [12:0] w_err, w_err_abs, w_err_sh;
    logic signed [17:0] w_step, w_sum;
    logic               w_in_band;

    assign w_err     = $signed({1'b0, TARGET}) - $signed({1'b0, env});
    // |err| is at most 4095, so it always fits in the signed 13-bit range
    assign w_err_abs = w_err[12] ? -w_err : w_err;
    assign w_in_band = (w_err_abs <= c_DBAND);
    // Too loud (negative error) reacts fast; too quiet reacts slowly
    assign w_err_sh  = w_err[12] ? (w_err >>> ATTACK_SHIFT) : (w_err >>> DECAY_SHIFT);
    assign w_step    = {{5{w_err_sh[12]}}, w_err_sh};
    // The sum is 18 bits wide so the clamp sees any over/underflow
    // before it could wrap at 16 bits
    assign w_sum     = $signed({2'b00, gain_q}) + w_step;

    always_comb begin
        gain_d     = gain_q;
        lock_cnt_d = lock_cnt_q;
        if (env_valid && !hold) begin
            if (w_in_band) begin
                if (lock_cnt_q != c_LOCK_MAX) begin
                    lock_cnt_d = lock_cnt_q + c_LOCK_ONE;
                end
            end else begin
                lock_cnt_d = '0;
                if (w_sum < c_GMIN) begin
                    gain_d = GAIN_MIN;
                end else if (w_sum > c_GMAX) begin
                    gain_d = GAIN_MAX;
                end else begin
                    gain_d = w_sum[15:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            gain_q     <= GAIN_INIT;
            lock_cnt_q <= '0;
            s1_valid_q <= 1'b0;
            s1_i_q     <= '0;
            s1_q_q     <= '0;
            out_valid  <= 1'b0;
            out_i      <= '0;
            out_q      <= '0;
            out_sat    <= 1'b0;
        end else begin
            gain_q     <= gain_d;
            lock_cnt_q <= lock_cnt_d;

            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_i_q <= w_s1_i;
                s1_q_q <= w_s1_q;
            end

            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                out_i   <= w_sat_i[11:0];
                out_q   <= w_sat_q[11:0];
                out_sat <= w_sat_i[12] | w_sat_q[12];
            end
        end
    end

    assign gain   = gain_q;
    assign locked = (lock_cnt_q == c_LOCK_MAX);

endmodule
`default_nettype wire

// File: tb/tb_agc_gain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_agc_gain_ctrl
//  Description : Self-checking bench for agc_gain_ctrl. Driven samples push
//                their expected outputs (with due cycle) to a scoreboard
//                queue, and a monitor pops and compares them as the DUT emits
//                them. The gain and lock state are tracked by a behavioural
//                model of the loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_agc_gain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] sample_i, sample_q;
    logic        env_valid;
    logic [11:0] env;
    logic        hold;
    logic        out_valid;
    logic [11:0] out_i, out_q;
    logic        out_sat;
    logic [15:0] gain;
    logic        locked;

    always #5 clk = ~clk;

    agc_gain_ctrl dut (
        .i_clk    (clk),
        .i_rst    (rst_n),
        .in_valid (in_valid),
        .sample_i (sample_i),
        .sample_q (sample_q),
        .env_valid(env_valid),
        .env      (env),
        .hold     (hold),
        .out_valid(out_valid),
        .out_i    (out_i),
        .out_q    (out_q),
        .out_sat  (out_sat),
        .gain     (gain),
        .locked   (locked)
    );

    typedef struct {
        int          due;
        logic [11:0] oi;
        logic [11:0] oq;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   m_gain  = 256;
    int   m_lock  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int clip(input int v);
        if (v > 2047)  return 2047;
        if (v < -2047) return -2047;
        return v;
    endfunction

    function automatic exp_t model_out(input logic [11:0] si, input logic [11:0] sq,
                                       input int g, input int due);
        exp_t e;
        int   vi, vq;
        vi    = (int'($signed(si)) * g) >>> 8;
        vq    = (int'($signed(sq)) * g) >>> 8;
        e.due = due;
        e.oi  = 12'(clip(vi));
        e.oq  = 12'(clip(vq));
        e.sat = (clip(vi) != vi) || (clip(vq) != vq);
        return e;
    endfunction

    task automatic model_env(input logic [11:0] e);
        int err, mag, stp;
        err = 1024 - int'(e);
        mag = (err < 0) ? -err : err;
        if (mag <= 16) begin
            if (m_lock < 8) m_lock++;
        end else begin
            stp    = (err < 0) ? (err >>> 2) : (err >>> 6);
            m_gain = m_gain + stp;
            if (m_gain < 16)   m_gain = 16;
            if (m_gain > 4096) m_gain = 4096;
            m_lock = 0;
        end
    endtask

    // Called just after a rising edge; drives one cycle of stimulus.
    task automatic cyc_drive(input bit vi, input logic [11:0] si, input logic [11:0] sq,
                             input bit ve, input logic [11:0] e, input bit h);
        in_valid  = vi;
        sample_i  = si;
        sample_q  = sq;
        env_valid = ve;
        env       = e;
        hold      = h;
        if (vi) sb.push_back(model_out(si, sq, m_gain, cyc + 2));
        if (ve && !h) model_env(e);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        env_valid = 1'b0;
        if (ve) begin
            check("gain", 32'(gain), 32'(m_gain));
            check("locked", 32'(locked), 32'(m_lock == 8));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc_drive(1'b0, 12'd0, 12'd0, 1'b0, 12'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        m_gain = 256;
        m_lock = 0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_gain", 32'(gain), 32'h100);
        check("rst_locked", 32'(locked), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("stray_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("latency", 32'(cyc), 32'(mon_e.due));
                    check("out_i", 32'(out_i), 32'(mon_e.oi));
                    check("out_q", 32'(out_q), 32'(mon_e.oq));
                    check("out_sat", 32'(out_sat), 32'(mon_e.sat));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_e = sb.pop_front();
                check("missing_out_valid", 32'(out_valid), 32'd1);
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got=running required=done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sample_i  = '0;
        sample_q  = '0;
        env_valid = 1'b0;
        env       = '0;
        hold      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_i", 32'(out_i), 32'd0);
        check("reset_out_q", 32'(out_q), 32'd0);
        check("reset_out_sat", 32'(out_sat), 32'd0);
        check("reset_gain", 32'(gain), 32'h100);
        check("reset_locked", 32'(locked), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unity gain, plus -2048 which must clip to -2047
        cyc_drive(1'b1, 12'd1024, 12'hE00, 1'b0, 12'd0, 1'b0);
        cyc_drive(1'b1, 12'h800, 12'd5, 1'b0, 12'd0, 1'b0);
        idle(3);

        // Attack: env=1536 -> gain 0x80, then 1000 -> 500
        cyc_drive(1'b0, 12'd0, 12'd0, 1'b1, 12'd1536, 1'b0);
        check("attack_gain", 32'(gain), 32'h80);
        cyc_drive(1'b1, 12'd1000, 12'hC18, 1'b0, 12'd0, 1'b0);
        idle(3);

        // Sample and env pulse in the same cycle: sample sees the old gain
        cyc_drive(1'b1, 12'd1000, 12'd300, 1'b1, 12'd0, 1'b0);
        cyc_drive(1'b1, 12'd1000, 12'd300, 1'b0, 12'd0, 1'b0);
        idle(3);

        // Random stream with interleaved envelope updates and hold
        for (int k = 0; k < 40; k++) begin
            cyc_drive(1'($urandom_range(0, 3) != 0), 12'($urandom), 12'($urandom),
                      1'($urandom_range(0, 3) == 0), 12'($urandom_range(900, 1200)),
                      1'($urandom_range(0, 7) == 0));
        end
        idle(3);

        // Decay up to the upper clamp and stay there
        for (int k = 0; k < 260; k++) cyc_drive(1'b0, 12'd0, 12'd0, 1'b1, 12'd0, 1'b0);
        check("gain_max", 32'(gain), 32'h1000);
        cyc_drive(1'b1, 12'd100, 12'hFFF, 1'b0, 12'd0, 1'b0);
        idle(3);

        // Attack down to the lower clamp and stay there
        for (int k = 0; k < 10; k++) cyc_drive(1'b0, 12'd0, 12'd0, 1'b1, 12'd4095, 1'b0);
        check("gain_min", 32'(gain), 32'h10);
        cyc_drive(1'b1, 12'd1000, 12'hC18, 1'b0, 12'd0, 1'b0);
        idle(3);

        // Saturation at gain 4.0
        do_reset();
        for (int k = 0; k < 48; k++) cyc_drive(1'b0, 12'd0, 12'd0, 1'b1, 12'd0, 1'b0);
        check("gain_x4", 32'(gain), 32'h400);
        cyc_drive(1'b1, 12'd1000, 12'h800, 1'b0, 12'd0, 1'b0);
        cyc_drive(1'b1, 12'd300, 12'hF00, 1'b0, 12'd0, 1'b0);
        idle(3);

        // Lock, hold, unlock
        do_reset();
        for (int k = 0; k < 8; k++) cyc_drive(1'b0, 12'd0, 12'd0, 1'b1, 12'd1030, 1'b0);
        check("lock_after_8", 32'(locked), 32'd1);
        check("lock_gain", 32'(gain), 32'h100);
        cyc_drive(1'b0, 12'd0, 12'd0, 1'b1, 12'd1500, 1'b1);
        check("hold_locked", 32'(locked), 32'd1);
        check("hold_gain", 32'(gain), 32'h100);
        cyc_drive(1'b0, 12'd0, 12'd0, 1'b1, 12'd1500, 1'b0);
        check("unlock_locked", 32'(locked), 32'd0);
        check("unlock_gain", 32'(gain), 32'd137);

        // Mid-stream reset while locked with samples in flight
        for (int k = 0; k < 12; k++) begin
            cyc_drive(1'b1, 12'($urandom), 12'($urandom), 1'(k < 8), 12'd1024, 1'b0);
        end
        check("pre_reset_locked", 32'(locked), 32'd1);
        cyc_drive(1'b1, 12'd700, 12'd800, 1'b0, 12'd0, 1'b0);
        do_reset();
        idle(6);
        cyc_drive(1'b1, 12'd123, 12'hF85, 1'b0, 12'd0, 1'b0);
        idle(4);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/agc_gain_ctrl.md
# agc_gain_ctrl

Gain-control half of the AGC loop: applies a programmable Q8.8 gain to the 12-bit I/Q sample stream and closes the loop using the envelope magnitude measured downstream on its own output. The envelope detector measures and this block drives, so they form a feedback pair: out_i/out_q feed the envelope detector, and its result returns on env/env_valid. The block sits between the ADC/decimator front end and the demodulator.

## Interface
- TARGET, 12'd1024: desired envelope magnitude (unsigned).
- DEADBAND, 12'd16: |error| ≤ DEADBAND gives no gain update.
- ATTACK_SHIFT, 2: right-shift applied to negative error (signal too loud).
- DECAY_SHIFT, 6: right-shift applied to positive error (signal too quiet).
- GAIN_INIT, 16'h0100: reset gain (1.0 in Q8.8).
- GAIN_MIN, 16'h0010: lower gain clamp.
- GAIN_MAX, 16'h1000: upper gain clamp.
- LOCK_COUNT, 8: consecutive in-deadband updates required to assert locked.
- i_clk  in  1  system clock (100 MHz).
- i_rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  sample_i/sample_q valid this cycle.
- sample_i  in  12  I sample, two's complement.
- sample_q  in  12  Q sample, two's complement.
- env_valid  in  1  env valid this cycle (single-cycle pulse).
- env  in  12  measured output envelope, unsigned.
- hold  in  1  freeze gain and lock counter.
- out_valid  out  1  out_i/out_q valid.
- out_i  out  12  gained I, two's complement.
- out_q  out  12  gained Q, two's complement.
- out_sat  out  1  at least one channel clipped on this output sample.
- gain  out  16  current gain register, Q8.8 unsigned.
- locked  out  1  loop settled.

## Operation
- Reset (i_rst low, asynchronous): gain=GAIN_INIT, out_valid=0, out_i=out_q=0, out_sat=0, locked=0, lock counter=0, pipeline valids cleared. Reset takes effect immediately, mid-stream included; any in-flight samples are discarded.
- Datapath, stage 1 (in_valid): product = sample × {1'b0, gain}, signed, 29-bit. Shift right arithmetically by 8, with truncation toward −inf.
- Datapath, stage 2: saturate each channel symmetrically to [−2047, +2047]. out_sat=1 if either channel clipped.
- Input −2048 at gain 1.0 yields −2047 with out_sat=1.
- Samples continue to flow while hold=1 or while the gain is updating; gain is never stalled.
- Gain loop, on env_valid=1 and hold=0:
  - err = TARGET − env, signed 13-bit.
  - If |err| ≤ DEADBAND: gain unchanged; lock counter increments and saturates at LOCK_COUNT.
  - Otherwise: step = err >>> ATTACK_SHIFT when err<0, else err >>> DECAY_SHIFT. Arithmetic shift, sign-extended to 18 bits.
  - Otherwise, continued: gain_next = clamp(gain + step, GAIN_MIN, GAIN_MAX). Lock counter is cleared; locked drops the next cycle.
- locked=1 whenever lock counter == LOCK_COUNT.
- hold=1: env_valid is ignored entirely, so neither gain nor lock counter changes.
- The clamp is evaluated on the full-width sum, so there is no wrap-around at 16 bits.

## Timing
- in_valid at cycle N gives out_valid, out_i, out_q and out_sat at N+2. Throughput is one sample per cycle, and out_valid is 0 in all other cycles.
- The gain used for a sample is the gain register value in the cycle in_valid is sampled.
- env_valid at cycle N: the new gain is visible on the gain output at N+1. It is first applied to a sample accepted at N+1.
- in_valid and env_valid in the same cycle: that sample uses the old gain.
- locked updates at N+1 after the qualifying env_valid.
- Reset release is synchronous to the first i_clk rising edge after deassertion. No output changes before that edge.

## Test plan
- Unity gain: after reset, feed sample_i=1024, sample_q=−512 at cycle 0 -> out_i=1024, out_q=−512, out_valid=1 at cycle 2, out_sat=0, gain=0x0100.
- Attack: env=1536, env_valid pulse -> err=−512, step=−128, gain=0x0080 next cycle. Then sample_i=1000 -> out_i=500.
- Decay and clamp: repeated env=0 pulses -> gain rises by 0x10 per pulse, stops at 0x1000 and holds on further pulses. Likewise, env=4095 pulses drive gain down to 0x0010 and it stays there.
- Saturation: force gain to 0x0400, sample_i=1000, sample_q=−2048 -> out_i=2047, out_q=−2047, out_sat=1.
- Lock and hold: 8 pulses of env=1030 -> locked=1 after the 8th, gain unchanged. Then env=1500 with hold=1 -> no change. Then the same env=1500 with hold=0 -> locked=0, gain drops by 119.
- Reset mid-stream: assert i_rst low during a burst of samples -> out_valid=0, gain=0x0100 and locked=0 immediately. No stale output appears after release.
